// File: rtl/cv32e40x_rvfi_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | cv32e40x_rvfi_pkg: RVFI packet and trace-beat types plus lane scan |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package cv32e40x_rvfi_pkg;

  localparam int NMEM   = 2;
  localparam int LANE_W = (NMEM > 1) ? $clog2(NMEM) : 1;

  typedef struct packed {
    logic [31:0]       pc;
    logic [4:0]        rd_addr;
    logic [31:0]       rd_wdata;
    logic [LANE_W-1:0] lane;
    logic [31:0]       mem_addr;
    logic [3:0]        rmask;
    logic [31:0]       rdata;
    logic [3:0]        wmask;
    logic [31:0]       wdata;
  } rvfi_trace_beat_t;

  typedef struct packed {
    logic [31:0]        pc;
    logic [4:0]         rd_addr;
    logic [31:0]        rd_wdata;
    logic [32*NMEM-1:0] mem_addr;
    logic [4*NMEM-1:0]  mem_rmask;
    logic [4*NMEM-1:0]  mem_wmask;
    logic [32*NMEM-1:0] mem_rdata;
    logic [32*NMEM-1:0] mem_wdata;
  } rvfi_trace_pkt_t;

  function automatic logic [NMEM-1:0] lane_active(input rvfi_trace_pkt_t p);
    logic [NMEM-1:0] act;
    act = '0;
    for (int i = 0; i < NMEM; i++) begin
      act[i] = |(p.mem_rmask[4*i +: 4] | p.mem_wmask[4*i +: 4]);
    end
    return act;
  endfunction

  // Lanes strictly above the given index, used to find the next beat.
  function automatic logic [NMEM-1:0] lanes_above(input logic [NMEM-1:0] m,
                                                  input logic [LANE_W-1:0] lane);
    logic [NMEM-1:0] r;
    r = '0;
    for (int i = 0; i < NMEM; i++) begin
      r[i] = m[i] && (i > int'(lane));
    end
    return r;
  endfunction

  function automatic logic [LANE_W-1:0] lowest_lane(input logic [NMEM-1:0] m);
    logic [LANE_W-1:0] idx;
    idx = '0;
    for (int i = NMEM - 1; i >= 0; i--) begin
      if (m[i]) idx = LANE_W'(i);
    end
    return idx;
  endfunction

  function automatic rvfi_trace_beat_t make_beat(input rvfi_trace_pkt_t p,
                                                 input logic [LANE_W-1:0] lane);
    rvfi_trace_beat_t b;
    b          = '0;
    b.pc       = p.pc;
    b.rd_addr  = p.rd_addr;
    b.rd_wdata = p.rd_wdata;
    // A packet without memory activity yields an all-zero lane view.
    if (|lane_active(p)) begin
      b.lane     = lane;
      b.mem_addr = p.mem_addr[32*int'(lane) +: 32];
      b.rmask    = p.mem_rmask[4*int'(lane) +: 4];
      b.rdata    = p.mem_rdata[32*int'(lane) +: 32];
      b.wmask    = p.mem_wmask[4*int'(lane) +: 4];
      b.wdata    = p.mem_wdata[32*int'(lane) +: 32];
    end
    return b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cv32e40x_rvfi_trace_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | cv32e40x_rvfi_trace_fifo: packet FIFO exposing head and next entry |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module cv32e40x_rvfi_trace_fifo
  import cv32e40x_rvfi_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push,
  input  logic            pop,
  input  rvfi_trace_pkt_t wdata,
  output rvfi_trace_pkt_t head,
  output rvfi_trace_pkt_t head2,
  output logic            full,
  output logic            empty,
  output logic            more
);

  localparam int AW = $clog2(DEPTH);

  rvfi_trace_pkt_t mem [DEPTH];
  logic [AW:0]     wptr;
  logic [AW:0]     rptr;
  logic [AW:0]     rptr_nxt;
  logic [AW:0]     count;

  assign rptr_nxt = rptr + (AW+1)'(1);
  assign count    = wptr - rptr;
  assign empty    = (wptr == rptr);
  assign full     = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign more     = (count > (AW+1)'(1));
  assign head     = mem[rptr[AW-1:0]];
  assign head2    = mem[rptr_nxt[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + (AW+1)'(1);
      if (pop)  rptr <= rptr_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr[AW-1:0]] <= wdata;
  end

endmodule
`default_nettype wire

// File: rtl/cv32e40x_rvfi_trace_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | cv32e40x_rvfi_trace_sequencer: RVFI packets to per-lane trace beats|
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module cv32e40x_rvfi_trace_sequencer
  import cv32e40x_rvfi_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                rvfi_valid,
  input  logic [31:0]         rvfi_pc_rdata,
  input  logic [4:0]          rvfi_rd_addr,
  input  logic [31:0]         rvfi_rd_wdata,
  input  logic [32*NMEM-1:0]  rvfi_mem_addr,
  input  logic [4*NMEM-1:0]   rvfi_mem_rmask,
  input  logic [4*NMEM-1:0]   rvfi_mem_wmask,
  input  logic [32*NMEM-1:0]  rvfi_mem_rdata,
  input  logic [32*NMEM-1:0]  rvfi_mem_wdata,
  input  logic                trace_ready_i,
  output logic                trace_valid_o,
  output rvfi_trace_beat_t    trace_beat_o,
  output logic                trace_last_o,
  output logic                overflow_o,
  output logic [CNT_W-1:0]    drop_cnt_o
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] EMIT = 1'b1;

  logic [0:0]        state;
  rvfi_trace_pkt_t   in_pkt;
  rvfi_trace_pkt_t   head;
  rvfi_trace_pkt_t   head2;
  rvfi_trace_pkt_t   sel_pkt;
  logic [LANE_W-1:0] sel_lane;
  logic              sel_last;
  logic              full;
  logic              empty;
  logic              more;
  logic              handshake;
  logic              pop;
  logic              push;
  logic              drop;
  logic              load;

  always_comb begin
    in_pkt.pc        = rvfi_pc_rdata;
    in_pkt.rd_addr   = rvfi_rd_addr;
    in_pkt.rd_wdata  = rvfi_rd_wdata;
    in_pkt.mem_addr  = rvfi_mem_addr;
    in_pkt.mem_rmask = rvfi_mem_rmask;
    in_pkt.mem_wmask = rvfi_mem_wmask;
    in_pkt.mem_rdata = rvfi_mem_rdata;
    in_pkt.mem_wdata = rvfi_mem_wdata;
  end

  assign handshake = trace_valid_o && trace_ready_i;
  assign pop       = handshake && trace_last_o;
  // The slot freed by a final-beat pop is reusable on the same edge.
  assign push      = rvfi_valid && (!full || pop);
  assign drop      = rvfi_valid && full && !pop;

  cv32e40x_rvfi_trace_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .wdata (in_pkt),
    .head  (head),
    .head2 (head2),
    .full  (full),
    .empty (empty),
    .more  (more)
  );

  // Pick the next beat source: next lane of the head, or the following packet.
  always_comb begin
    sel_pkt  = head;
    sel_lane = lowest_lane(lane_active(head));
    if (state == EMIT) begin
      if (!trace_last_o) begin
        sel_lane = lowest_lane(lanes_above(lane_active(head), trace_beat_o.lane));
      end else begin
        sel_pkt  = head2;
        sel_lane = lowest_lane(lane_active(head2));
      end
    end
    sel_last = ~|lanes_above(lane_active(sel_pkt), sel_lane);
  end

  assign load = (state == IDLE) ? !empty : (handshake && (!trace_last_o || more));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      trace_valid_o <= 1'b0;
      trace_last_o  <= 1'b0;
      trace_beat_o  <= '0;
    end else if (load) begin
      state         <= EMIT;
      trace_valid_o <= 1'b1;
      trace_last_o  <= sel_last;
      trace_beat_o  <= make_beat(sel_pkt, sel_lane);
    end else if (pop) begin
      state         <= IDLE;
      trace_valid_o <= 1'b0;
      trace_last_o  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_o <= 1'b0;
      drop_cnt_o <= '0;
    end else if (drop) begin
      overflow_o <= 1'b1;
      if (drop_cnt_o != '1) drop_cnt_o <= drop_cnt_o + CNT_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cv32e40x_rvfi_trace_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_cv32e40x_rvfi_trace_sequencer: directed + random beat checking  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_cv32e40x_rvfi_trace_sequencer;
  import cv32e40x_rvfi_pkg::*;

  localparam int DEPTH = 4;
  localparam int CNT_W = 16;

  typedef struct packed {
    rvfi_trace_beat_t beat;
    logic             last;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               rvfi_valid;
  logic [31:0]        rvfi_pc_rdata;
  logic [4:0]         rvfi_rd_addr;
  logic [31:0]        rvfi_rd_wdata;
  logic [32*NMEM-1:0] rvfi_mem_addr;
  logic [4*NMEM-1:0]  rvfi_mem_rmask;
  logic [4*NMEM-1:0]  rvfi_mem_wmask;
  logic [32*NMEM-1:0] rvfi_mem_rdata;
  logic [32*NMEM-1:0] rvfi_mem_wdata;
  logic               trace_ready_i;
  logic               trace_valid_o;
  rvfi_trace_beat_t   trace_beat_o;
  logic               trace_last_o;
  logic               overflow_o;
  logic [CNT_W-1:0]   drop_cnt_o;

  int   n_assert = 0;
  int   n_fail   = 0;
  int   outstanding = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  cv32e40x_rvfi_trace_sequencer #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rvfi_valid     (rvfi_valid),
    .rvfi_pc_rdata  (rvfi_pc_rdata),
    .rvfi_rd_addr   (rvfi_rd_addr),
    .rvfi_rd_wdata  (rvfi_rd_wdata),
    .rvfi_mem_addr  (rvfi_mem_addr),
    .rvfi_mem_rmask (rvfi_mem_rmask),
    .rvfi_mem_wmask (rvfi_mem_wmask),
    .rvfi_mem_rdata (rvfi_mem_rdata),
    .rvfi_mem_wdata (rvfi_mem_wdata),
    .trace_ready_i  (trace_ready_i),
    .trace_valid_o  (trace_valid_o),
    .trace_beat_o   (trace_beat_o),
    .trace_last_o   (trace_last_o),
    .overflow_o     (overflow_o),
    .drop_cnt_o     (drop_cnt_o)
  );

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected beats: one per lane whose read or write mask is non-zero, lowest lane first.
  function automatic void model_push(input rvfi_trace_pkt_t p);
    int   act[$];
    exp_t e;
    for (int i = 0; i < NMEM; i++) begin
      if (p.mem_rmask[4*i +: 4] != 4'h0 || p.mem_wmask[4*i +: 4] != 4'h0) act.push_back(i);
    end
    e = '0;
    e.beat.pc       = p.pc;
    e.beat.rd_addr  = p.rd_addr;
    e.beat.rd_wdata = p.rd_wdata;
    if (act.size() == 0) begin
      e.last = 1'b1;
      exp_q.push_back(e);
    end else begin
      for (int k = 0; k < act.size(); k++) begin
        int ln;
        ln = act[k];
        e.beat.lane     = LANE_W'(ln);
        e.beat.mem_addr = p.mem_addr[32*ln +: 32];
        e.beat.rmask    = p.mem_rmask[4*ln +: 4];
        e.beat.rdata    = p.mem_rdata[32*ln +: 32];
        e.beat.wmask    = p.mem_wmask[4*ln +: 4];
        e.beat.wdata    = p.mem_wdata[32*ln +: 32];
        e.last          = (k == act.size() - 1);
        exp_q.push_back(e);
      end
    end
    outstanding++;
  endfunction

  function automatic rvfi_trace_pkt_t rand_pkt();
    rvfi_trace_pkt_t p;
    p.pc        = $urandom;
    p.rd_addr   = 5'($urandom);
    p.rd_wdata  = $urandom;
    for (int i = 0; i < NMEM; i++) begin
      p.mem_addr[32*i +: 32]  = $urandom;
      p.mem_rdata[32*i +: 32] = $urandom;
      p.mem_wdata[32*i +: 32] = $urandom;
      p.mem_rmask[4*i +: 4]   = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
      p.mem_wmask[4*i +: 4]   = ($urandom_range(0, 2) == 2) ? 4'($urandom) : 4'h0;
    end
    return p;
  endfunction

  task automatic drive(input rvfi_trace_pkt_t p);
    rvfi_valid     = 1'b1;
    rvfi_pc_rdata  = p.pc;
    rvfi_rd_addr   = p.rd_addr;
    rvfi_rd_wdata  = p.rd_wdata;
    rvfi_mem_addr  = p.mem_addr;
    rvfi_mem_rmask = p.mem_rmask;
    rvfi_mem_wmask = p.mem_wmask;
    rvfi_mem_rdata = p.mem_rdata;
    rvfi_mem_wdata = p.mem_wdata;
  endtask

  // One clock: score any beat handshaken at the coming edge, then check stall stability.
  task automatic step();
    logic             pv;
    logic             pr;
    logic             pl;
    rvfi_trace_beat_t pb;
    exp_t             e;
    pv = trace_valid_o;
    pr = trace_ready_i;
    pl = trace_last_o;
    pb = trace_beat_o;
    if (pv && pr) begin
      chk("beat_expected", 256'(exp_q.size() != 0), 256'(1));
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("beat", 256'(pb), 256'(e.beat));
        chk("last", 256'(pl), 256'(e.last));
        if (e.last) outstanding--;
      end
    end
    @(posedge clk);
    @(negedge clk);
    if (pv && !pr) begin
      chk("stall_valid", 256'(trace_valid_o), 256'(1));
      chk("stall_beat", 256'(trace_beat_o), 256'(pb));
      chk("stall_last", 256'(trace_last_o), 256'(pl));
    end
  endtask

  task automatic drain(input string tag);
    trace_ready_i = 1'b1;
    for (int c = 0; c < 500 && exp_q.size() != 0; c++) step();
    chk(tag, 256'(exp_q.size()), 256'(0));
  endtask

  initial begin
    rvfi_trace_pkt_t p;
    rst_n          = 1'b0;
    rvfi_valid     = 1'b0;
    rvfi_pc_rdata  = '0;
    rvfi_rd_addr   = '0;
    rvfi_rd_wdata  = '0;
    rvfi_mem_addr  = '0;
    rvfi_mem_rmask = '0;
    rvfi_mem_wmask = '0;
    rvfi_mem_rdata = '0;
    rvfi_mem_wdata = '0;
    trace_ready_i  = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", 256'(trace_valid_o), 256'(0));
    chk("rst_last", 256'(trace_last_o), 256'(0));
    chk("rst_beat", 256'(trace_beat_o), 256'(0));
    chk("rst_ovf", 256'(overflow_o), 256'(0));
    chk("rst_cnt", 256'(drop_cnt_o), 256'(0));
    rst_n = 1'b1;
    step();

    // No memory op: single zero-lane beat, valid one edge after the push.
    p = rand_pkt();
    p.pc = 32'h80;
    p.mem_rmask = '0;
    p.mem_wmask = '0;
    trace_ready_i = 1'b1;
    drive(p);
    model_push(p);
    step();
    rvfi_valid = 1'b0;
    chk("t1_lat_n", 256'(trace_valid_o), 256'(0));
    step();
    chk("t1_lat_n1", 256'(trace_valid_o), 256'(1));
    step();
    chk("t1_done", 256'(trace_valid_o), 256'(0));
    chk("t1_empty", 256'(exp_q.size()), 256'(0));

    // Read on lane 0, write on lane 1.
    p = rand_pkt();
    p.mem_rmask = {4'h0, 4'hF};
    p.mem_wmask = {4'h3, 4'h0};
    drive(p);
    model_push(p);
    step();
    rvfi_valid = 1'b0;
    drain("t2_drain");

    // Five-cycle stall after the first beat of a two-lane packet.
    p = rand_pkt();
    p.mem_rmask = {4'h1, 4'h2};
    trace_ready_i = 1'b0;
    drive(p);
    model_push(p);
    step();
    rvfi_valid = 1'b0;
    step();
    trace_ready_i = 1'b1;
    step();
    trace_ready_i = 1'b0;
    repeat (5) step();
    drain("t3_drain");

    // Lane 0 idle, only lane 1 active.
    p = rand_pkt();
    p.mem_rmask = {4'h8, 4'h0};
    p.mem_wmask = '0;
    drive(p);
    model_push(p);
    step();
    rvfi_valid = 1'b0;
    drain("skip_drain");

    // DEPTH+2 single-beat packets with the sink stalled: last two dropped.
    trace_ready_i = 1'b0;
    for (int k = 0; k < DEPTH + 2; k++) begin
      p = rand_pkt();
      p.mem_rmask[7:4] = 4'h0;
      p.mem_wmask[7:4] = 4'h0;
      drive(p);
      if (k < DEPTH) model_push(p);
      step();
    end
    rvfi_valid = 1'b0;
    chk("t4_ovf", 256'(overflow_o), 256'(1));
    chk("t4_cnt", 256'(drop_cnt_o), 256'(2));

    // Full FIFO: push coincides with the pop of a final beat.
    p = rand_pkt();
    trace_ready_i = 1'b1;
    drive(p);
    model_push(p);
    step();
    rvfi_valid = 1'b0;
    chk("t5_cnt", 256'(drop_cnt_o), 256'(2));
    drain("t45_drain");
    chk("t5_ovf_sticky", 256'(overflow_o), 256'(1));

    // Asynchronous reset in the middle of a packet.
    p = rand_pkt();
    p.mem_rmask = {4'hF, 4'hF};
    trace_ready_i = 1'b0;
    drive(p);
    step();
    rvfi_valid = 1'b0;
    step();
    chk("t6_pre_valid", 256'(trace_valid_o), 256'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_valid", 256'(trace_valid_o), 256'(0));
    chk("t6_async_ovf", 256'(overflow_o), 256'(0));
    chk("t6_async_cnt", 256'(drop_cnt_o), 256'(0));
    exp_q.delete();
    outstanding = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    trace_ready_i = 1'b1;
    repeat (3) step();
    chk("t6_post_valid", 256'(trace_valid_o), 256'(0));

    // Random traffic, pushing only while the FIFO cannot be full.
    for (int c = 0; c < 600; c++) begin
      trace_ready_i = ($urandom_range(0, 3) != 0);
      if (outstanding < DEPTH && $urandom_range(0, 1) == 1) begin
        p = rand_pkt();
        drive(p);
        model_push(p);
      end else begin
        drive(rand_pkt());
        rvfi_valid = 1'b0;
      end
      step();
    end
    rvfi_valid = 1'b0;
    drain("rand_drain");
    chk("rand_ovf", 256'(overflow_o), 256'(0));
    chk("rand_cnt", 256'(drop_cnt_o), 256'(0));
    step();
    chk("rand_idle", 256'(trace_valid_o), 256'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
